// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the fetch port (i_*) and
// the load/store port (d_*). One access is granted per IDLE cycle; writes
// finish in the grant cycle, reads occupy the RAM one more cycle (RD_WAIT)
// while the data is returned to the owning port.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   i_req_i/i_addr_i               fetch request (always a read)
//   i_gnt_o/i_rvalid_o/i_rdata_o   fetch grant and read-data return
//   d_req_i/d_addr_i/d_wdata_i/d_wmask_i  load/store request (mask 0 = load)
//   d_gnt_o/d_rvalid_o/d_rdata_o   load/store grant and load-data return
//   ram_en_o/ram_addr_o/ram_wdata_o/ram_wmask_o/ram_rdata_i  RAM side
//
// Parameters:
//   API_ADDR_WIDTH, API_DATA_WIDTH  bus widths
//   STARVE_LIMIT (1..15)            consecutive D wins before a waiting I wins
//
// Compile option:
//   MEM_ARB_RR_EN  defined   -> round-robin on a 1-bit last-winner pointer
//                  undefined -> fixed D priority with starvation limit
module mem_arbiter #(
  parameter int unsigned API_ADDR_WIDTH = 32,
  parameter int unsigned API_DATA_WIDTH = 32,
  parameter int unsigned STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_req_i,
  input  logic [API_ADDR_WIDTH-1:0] i_addr_i,
  output logic                      i_gnt_o,
  output logic                      i_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] i_rdata_o,
  input  logic                      d_req_i,
  input  logic [API_ADDR_WIDTH-1:0] d_addr_i,
  input  logic [API_DATA_WIDTH-1:0] d_wdata_i,
  input  logic [3:0]                d_wmask_i,
  output logic                      d_gnt_o,
  output logic                      d_rvalid_o,
  output logic [API_DATA_WIDTH-1:0] d_rdata_o,
  output logic                      ram_en_o,
  output logic [API_ADDR_WIDTH-1:0] ram_addr_o,
  output logic [API_DATA_WIDTH-1:0] ram_wdata_o,
  output logic [3:0]                ram_wmask_o,
  input  logic [API_DATA_WIDTH-1:0] ram_rdata_i
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      r_owner_d;   // pending read belongs to D
  logic [API_ADDR_WIDTH-1:0] r_addr;      // pending read address
  logic                      w_d_wins;
  logic                      w_gnt_i;
  logic                      w_gnt_d;
  logic                      w_rd_grant;

`ifdef MEM_ARB_RR_EN
  logic r_last_i;  // 1: I won the most recent grant

  // When both request, the port that did not win last goes first.
  always_comb begin
    w_d_wins = d_req_i && (!i_req_i || r_last_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_i <= 1'b1;
    end else if (w_gnt_i || w_gnt_d) begin
      r_last_i <= w_gnt_i;
    end
  end
`else
  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;

  // D has priority until it has won LP_LIMIT times in a row over a waiting I.
  always_comb begin
    w_d_wins = d_req_i && (!i_req_i || (r_starve_cnt != LP_LIMIT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (!i_req_i || w_gnt_i) begin
      r_starve_cnt <= '0;
    end else if (w_gnt_d && (r_starve_cnt != LP_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`endif

  // Grants are only possible in IDLE; a lone I request wins because
  // w_d_wins is low whenever d_req_i is low.
  always_comb begin
    w_gnt_d    = (r_state == ST_IDLE) && w_d_wins;
    w_gnt_i    = (r_state == ST_IDLE) && i_req_i && !w_d_wins;
    w_rd_grant = w_gnt_i || (w_gnt_d && (d_wmask_i == 4'b0000));
  end

  // State register plus the read-owner/address capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_owner_d <= 1'b0;
      r_addr    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_rd_grant) begin
        r_owner_d <= w_gnt_d;
        r_addr    <= w_gnt_d ? d_addr_i : i_addr_i;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:    w_state_nxt = w_rd_grant ? ST_RD_WAIT : ST_IDLE;
      ST_RD_WAIT: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs. Gated by reset_n so everything, including the combinational
  // grants, reads zero while reset is held, whatever the requests are.
  always_comb begin
    i_gnt_o     = 1'b0;
    d_gnt_o     = 1'b0;
    i_rvalid_o  = 1'b0;
    d_rvalid_o  = 1'b0;
    i_rdata_o   = '0;
    d_rdata_o   = '0;
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = 4'b0000;
    if (reset_n) begin
      case (r_state)
        ST_IDLE: begin
          i_gnt_o = w_gnt_i;
          d_gnt_o = w_gnt_d;
          if (w_gnt_d) begin
            ram_en_o    = 1'b1;
            ram_addr_o  = d_addr_i;
            ram_wdata_o = d_wdata_i;
            ram_wmask_o = d_wmask_i;
          end else if (w_gnt_i) begin
            ram_en_o   = 1'b1;
            ram_addr_o = i_addr_i;
          end
        end
        ST_RD_WAIT: begin
          ram_en_o   = 1'b1;
          ram_addr_o = r_addr;
          if (r_owner_d) begin
            d_rvalid_o = 1'b1;
            d_rdata_o  = ram_rdata_i;
          end else begin
            i_rvalid_o = 1'b1;
            i_rdata_o  = ram_rdata_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a behavioural RAM, directed scenarios with
// literal expectations, and a randomized phase checked every cycle against a
// transaction-level model of the arbitration policy.
module tb_mem_arbiter;

  localparam int unsigned TB_STARVE = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wmask_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        ram_en_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [3:0]  ram_wmask_o;
  logic [31:0] ram_rdata_i = 32'h0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .API_ADDR_WIDTH(32),
    .API_DATA_WIDTH(32),
    .STARVE_LIMIT  (TB_STARVE)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .i_rdata_o  (i_rdata_o),
    .d_req_i    (d_req_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_wmask_i  (d_wmask_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .ram_en_o   (ram_en_o),
    .ram_addr_o (ram_addr_o),
    .ram_wdata_o(ram_wdata_o),
    .ram_wmask_o(ram_wmask_o),
    .ram_rdata_i(ram_rdata_i)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Synchronous RAM, 64 words, one-cycle read latency.
  logic [31:0] ram_mem [64] = '{8: 32'hDEADBEEF, default: 32'h0};

  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_wmask_o != 4'b0000)
        ram_mem[ram_addr_o[7:2]] <= merge(ram_mem[ram_addr_o[7:2]], ram_wdata_o, ram_wmask_o);
      else
        ram_rdata_i <= ram_mem[ram_addr_o[7:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the memory image seen by the arbiter's clients, the
  // read currently being returned (0 none, 1 I, 2 D), and the policy state.
  logic [31:0] m_mem [64] = '{8: 32'hDEADBEEF, default: 32'h0};
  int          m_pend   = 0;
  logic [31:0] m_paddr  = 32'h0;
  logic [31:0] m_pdata  = 32'h0;
  int          m_starve = 0;
  bit          m_last_i = 1'b1;

  always @(negedge clk) begin : p_cmp
    bit          win_d, win_i;
    logic        e_gi, e_gd, e_irv, e_drv, e_en;
    logic [31:0] e_ird, e_drd, e_addr, e_wd;
    logic [3:0]  e_wm;
    win_d = 1'b0; win_i = 1'b0;
    e_gi = 1'b0; e_gd = 1'b0; e_irv = 1'b0; e_drv = 1'b0; e_en = 1'b0;
    e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0; e_wm = '0;
    if (!reset_n) begin
      m_pend   = 0;
      m_starve = 0;
      m_last_i = 1'b1;
    end else if (m_pend != 0) begin
      e_en   = 1'b1;
      e_addr = m_paddr;
      if (m_pend == 2) begin e_drv = 1'b1; e_drd = m_pdata; end
      else             begin e_irv = 1'b1; e_ird = m_pdata; end
      m_pend = 0;
      if (!i_req_i) m_starve = 0;
    end else begin
      if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_RR_EN
        win_d = m_last_i;
`else
        win_d = (m_starve < int'(TB_STARVE));
`endif
        win_i = !win_d;
      end else begin
        win_d = d_req_i;
        win_i = i_req_i;
      end
      if (win_d) begin
        e_gd = 1'b1; e_en = 1'b1; e_addr = d_addr_i; e_wd = d_wdata_i; e_wm = d_wmask_i;
      end
      if (win_i) begin
        e_gi = 1'b1; e_en = 1'b1; e_addr = i_addr_i;
      end
      if (!i_req_i || win_i) m_starve = 0;
      else if (win_d && m_starve < int'(TB_STARVE)) m_starve++;
      if (win_d || win_i) m_last_i = win_i;
      if (win_i) begin
        m_pend = 1; m_paddr = i_addr_i; m_pdata = m_mem[i_addr_i[7:2]];
      end else if (win_d) begin
        if (d_wmask_i == 4'b0000) begin
          m_pend = 2; m_paddr = d_addr_i; m_pdata = m_mem[d_addr_i[7:2]];
        end else begin
          m_mem[d_addr_i[7:2]] = merge(m_mem[d_addr_i[7:2]], d_wdata_i, d_wmask_i);
        end
      end
    end
    check("cmp_i_gnt",     32'(i_gnt_o),     32'(e_gi));
    check("cmp_d_gnt",     32'(d_gnt_o),     32'(e_gd));
    check("cmp_i_rvalid",  32'(i_rvalid_o),  32'(e_irv));
    check("cmp_d_rvalid",  32'(d_rvalid_o),  32'(e_drv));
    check("cmp_i_rdata",   i_rdata_o,        e_ird);
    check("cmp_d_rdata",   d_rdata_o,        e_drd);
    check("cmp_ram_en",    32'(ram_en_o),    32'(e_en));
    check("cmp_ram_addr",  ram_addr_o,       e_addr);
    check("cmp_ram_wdata", ram_wdata_o,      e_wd);
    check("cmp_ram_wmask", 32'(ram_wmask_o), 32'(e_wm));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin : p_main
    logic [7:0] got [10];
    int         n;
    logic       gi, gd;

    reset_n = 1'b0;
    i_req_i = 1'b1;  i_addr_i = 32'h20;
    d_req_i = 1'b1;  d_addr_i = 32'h24;  d_wdata_i = 32'h0;  d_wmask_i = 4'b0000;
    @(negedge clk);
    check("reset_i_gnt",  32'(i_gnt_o),  32'h0);
    check("reset_d_gnt",  32'(d_gnt_o),  32'h0);
    check("reset_ram_en", 32'(ram_en_o), 32'h0);
    step();
    i_req_i = 1'b0;  d_req_i = 1'b0;
    step();
    reset_n = 1'b1;

    // Fetch only: grant in N, data in N+1, next grant no earlier than N+2.
    step();
    i_req_i = 1'b1;  i_addr_i = 32'h20;
    @(negedge clk);
    check("fetch_gnt",      32'(i_gnt_o), 32'h1);
    check("fetch_ram_addr", ram_addr_o,   32'h20);
    step();
    i_addr_i = 32'h24;
    @(negedge clk);
    check("fetch_rvalid", 32'(i_rvalid_o), 32'h1);
    check("fetch_rdata",  i_rdata_o,       32'hDEADBEEF);
    check("fetch_no_gnt", 32'(i_gnt_o),    32'h0);
    step();
    @(negedge clk);
    check("fetch_regnt_n2", 32'(i_gnt_o), 32'h1);
    step();
    i_req_i = 1'b0;

    // Byte store, full store back-to-back, then load of the byte-stored word.
    step();
    d_req_i = 1'b1;  d_addr_i = 32'h24;  d_wdata_i = 32'h11223344;  d_wmask_i = 4'b0011;
    @(negedge clk);
    check("store1_gnt", 32'(d_gnt_o), 32'h1);
    step();
    d_addr_i = 32'h28;  d_wdata_i = 32'hAABBCCDD;  d_wmask_i = 4'b1111;
    @(negedge clk);
    check("store2_gnt", 32'(d_gnt_o), 32'h1);
    step();
    d_addr_i = 32'h24;  d_wdata_i = 32'h0;  d_wmask_i = 4'b0000;
    @(negedge clk);
    check("load_gnt", 32'(d_gnt_o), 32'h1);
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    check("load_rvalid", 32'(d_rvalid_o), 32'h1);
    check("load_rdata",  d_rdata_o,       32'h00003344);

    // Contention: both ports request continuously, D loads only.
    do_reset();
    d_req_i = 1'b1;  d_wmask_i = 4'b0000;  d_addr_i = 32'($urandom_range(0, 255));
    i_req_i = 1'b1;  i_addr_i = 32'($urandom_range(0, 255));
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      gi = i_gnt_o;
      gd = d_gnt_o;
      if (gd) begin got[n] = "D"; n++; end
      else if (gi) begin got[n] = "I"; n++; end
      step();
      if (gd) d_addr_i = 32'($urandom_range(0, 255));
      if (gi) i_addr_i = 32'($urandom_range(0, 255));
    end
    if (n < 10) check("contention_grant_count", 32'(n), 32'd10);
    for (int k = 0; k < n; k++) begin
`ifdef MEM_ARB_RR_EN
      check("contention_seq", 32'(got[k]), (k % 2 == 1) ? 32'("I") : 32'("D"));
`else
      check("contention_seq", 32'(got[k]),
            (k % (TB_STARVE + 1) == TB_STARVE) ? 32'("I") : 32'("D"));
`endif
    end
    d_req_i = 1'b0;  i_req_i = 1'b0;
    step();
    step();

    // Reset asserted during RD_WAIT.
    i_req_i = 1'b1;  i_addr_i = 32'h20;
    @(negedge clk);
    check("rstmid_gnt", 32'(i_gnt_o), 32'h1);
    step();
    i_req_i = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_i_rvalid", 32'(i_rvalid_o), 32'h0);
    check("rstmid_i_rdata",  i_rdata_o,       32'h0);
    check("rstmid_ram_en",   32'(ram_en_o),   32'h0);
    check("rstmid_ram_addr", ram_addr_o,      32'h0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rstmid_no_rvalid", 32'(i_rvalid_o), 32'h0);
    step();
    d_req_i = 1'b1;  d_addr_i = 32'h28;  d_wmask_i = 4'b0000;
    @(negedge clk);
    check("rstmid_next_gnt", 32'(d_gnt_o), 32'h1);
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    check("rstmid_next_rdata", d_rdata_o, 32'hAABBCCDD);

    // Late request: D rises during the RD_WAIT of an I read.
    step();
    i_req_i = 1'b1;  i_addr_i = 32'h20;
    @(negedge clk);
    check("late_i_gnt", 32'(i_gnt_o), 32'h1);
    step();
    i_req_i = 1'b0;
    d_req_i = 1'b1;  d_addr_i = 32'h24;  d_wmask_i = 4'b0000;
    @(negedge clk);
    check("late_d_no_gnt", 32'(d_gnt_o),    32'h0);
    check("late_i_rvalid", 32'(i_rvalid_o), 32'h1);
    check("late_i_rdata",  i_rdata_o,       32'hDEADBEEF);
    step();
    @(negedge clk);
    check("late_d_gnt", 32'(d_gnt_o), 32'h1);
    step();
    d_req_i = 1'b0;
    @(negedge clk);
    check("late_d_rdata", d_rdata_o, 32'h00003344);

    // Randomized traffic; requests are held until granted, occasionally
    // withdrawn early.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      gi = i_gnt_o;
      gd = d_gnt_o;
      step();
      if (gi || !i_req_i) begin
        i_req_i  = ($urandom_range(0, 99) < 60);
        i_addr_i = 32'($urandom_range(0, 255));
      end else if ($urandom_range(0, 19) == 0) begin
        i_req_i = 1'b0;
      end
      if (gd || !d_req_i) begin
        d_req_i   = ($urandom_range(0, 99) < 60);
        d_addr_i  = 32'($urandom_range(0, 255));
        d_wdata_i = $urandom;
        d_wmask_i = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
      end else if ($urandom_range(0, 19) == 0) begin
        d_req_i = 1'b0;
      end
    end
    i_req_i = 1'b0;
    d_req_i = 1'b0;
    step();
    step();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port `mem_RAM` between the instruction-fetch port (I) and the load/store port (D) of the core. It picks one requester per access, drives the RAM chip-select, address, write data and byte mask, and returns read data to the winning port one cycle later. Writes complete in the grant cycle; reads hold the RAM for one extra cycle. Fixed D-over-I priority with a starvation limit is the default; round-robin is a compile option.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive D grants while `i_req_i` is held before I is forced to win. Legal range 1..15.

- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `i_req_i` in 1: fetch request, held until `i_gnt_o`
- `i_addr_i` in `API_ADDR_WIDTH`: fetch byte address; always a read
- `i_gnt_o` out 1: fetch request accepted this cycle
- `i_rvalid_o` out 1: fetch data valid
- `i_rdata_o` out `API_DATA_WIDTH`: fetch data
- `d_req_i` in 1: load/store request, held until `d_gnt_o`
- `d_addr_i` in `API_ADDR_WIDTH`: load/store byte address
- `d_wdata_i` in `API_DATA_WIDTH`: store data
- `d_wmask_i` in 4: byte write mask; 4'b0000 means load
- `d_gnt_o` out 1: load/store accepted this cycle
- `d_rvalid_o` out 1: load data valid (loads only)
- `d_rdata_o` out `API_DATA_WIDTH`: load data
- `ram_en_o` out 1: RAM chip select
- `ram_addr_o` out `API_ADDR_WIDTH`: RAM byte address
- `ram_wdata_o` out `API_DATA_WIDTH`: RAM write data
- `ram_wmask_o` out 4: RAM byte mask
- `ram_rdata_i` in `API_DATA_WIDTH`: RAM read data

## Operation
- FSM states: IDLE, RD_WAIT.
- **IDLE, no request:**
  - `ram_en_o` = 0.
  - Address, data and mask outputs are 0.
- **IDLE, one or both requests:**
  - The winner gets `*_gnt_o` = 1, combinationally, in the same cycle.
  - `ram_en_o` = 1, and the winner's address is driven.
  - D winner: `ram_wdata_o` = `d_wdata_i` and `ram_wmask_o` = `d_wmask_i`.
  - I winner: wmask = 0 and wdata = 0.
  - Write (wmask ≠ 0): stay in IDLE, so a new grant is possible next cycle.
  - Read: latch the owner and address, then go to RD_WAIT.
- **RD_WAIT:**
  - No grants.
  - `ram_en_o` = 1, latched address, wmask = 0.
  - The owner's `*_rvalid_o` = 1 and `*_rdata_o` = `ram_rdata_i`.
  - Always returns to IDLE after one cycle.
- The `*_rdata_o` of a port is 0 whenever that port's `*_rvalid_o` is 0.
- **Arbitration (default):**
  - A lone requester always wins.
  - When both request, D wins unless `starve_cnt` == `STARVE_LIMIT`, in which case I wins.
  - `starve_cnt` (4-bit) increments on each D grant while `i_req_i` = 1.
  - `starve_cnt` clears on an I grant or on any cycle with `i_req_i` = 0.
  - `starve_cnt` saturates at `STARVE_LIMIT`.
- Address bits [1:0] are passed through unmodified; the RAM ignores them. No alignment checking.
- Requests deasserted before grant are legal; no state is kept for them.

## Timing
- Reset (async, `reset_n` = 0):
  - State goes to IDLE; `starve_cnt` = 0; round-robin pointer = "I last".
  - All outputs are forced to 0, including the gnt outputs, regardless of the request inputs.
- Read latency: grant in cycle N, rvalid in cycle N+1. The earliest next grant is N+2.
- Write: grant in cycle N, and the RAM writes on the rising edge ending cycle N. The next grant can be in N+1 (one store per cycle).
- A request must be held stable (address, data, mask) until its gnt is seen; these values are sampled in the gnt cycle.
- Reset asserted during RD_WAIT: the pending read is discarded and no rvalid is ever produced for it.
- A request arriving in RD_WAIT waits until the next IDLE cycle, where it is arbitrated normally.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - A 1-bit last-winner pointer replaces fixed priority.
  - When both request, the port that did not win last gets the grant.
  - The pointer updates on every grant.
  - `starve_cnt` and `STARVE_LIMIT` are not used.
- `MEM_ARB_RR_EN` undefined: fixed D priority with starvation limit, as described above.

## Test plan
- Fetch only:
  - Stimulus: preload RAM word 0x8 = 0xDEADBEEF; `i_req_i` with addr 0x20 in cycle N.
  - Required: `i_gnt_o` in N; `i_rvalid_o` in N+1 with `i_rdata_o` = 0xDEADBEEF; no grant in N+1.
- Byte store then load:
  - Stimulus: D store to 0x24 with wdata 0x11223344 and mask 4'b0011; then a D load of 0x24.
  - Required: stores granted on back-to-back cycles; load returns 0x00003344.
- Contention (default build):
  - Stimulus: both ports request continuously with D loads only; `STARVE_LIMIT` = 4.
  - Required: grant pattern D,D,D,D,I repeating; `starve_cnt` returns to 0 after each I grant.
- Contention (`MEM_ARB_RR_EN` defined):
  - Stimulus: both ports request continuously.
  - Required: grants alternate D,I,D,I, with D first after reset.
- Reset mid-read:
  - Stimulus: assert `reset_n` = 0 during RD_WAIT.
  - Required: all outputs 0 immediately; no rvalid after release; the next request is granted in its first cycle.
- Late request:
  - Stimulus: `d_req_i` rises in the RD_WAIT of an I read.
  - Required: `d_gnt_o` in the following cycle; `i_rvalid_o` unaffected.
